serial_operand_feeder: RTL and testbench

SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

---
 rtl/serial_pkg.sv | 12 +
 rtl/serial_operand_feeder.sv | 118 +++++++++++
 tb/tb_serial_operand_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial operand feeder.
// FSM state encoding and the default operand width.
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int SERIAL_W_DEFAULT = 8;

endpackage

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for a bit-serial adder, LSB first.
// Optional abort input enabled by defining SERIAL_FEEDER_ABORT_EN.
module serial_operand_feeder
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_FEEDER_ABORT_EN
   input  logic             abort,
`endif
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             bit_first,
   output logic             bit_last,
   output logic             carry_clr
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic             abort_w;
   logic             last_w;

`ifdef SERIAL_FEEDER_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign last_w = (cnt_q == LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      in_ready  = 1'b1;
      bit_valid = 1'b0;
      a         = 1'b0;
      b         = 1'b0;
      bit_first = 1'b0;
      bit_last  = 1'b0;
      carry_clr = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = SHIFT;
               cnt_d     = '0;
               shift_a_d = in_a;
               shift_b_d = in_b;
            end
         end
         SHIFT: begin
            bit_valid = 1'b1;
            a         = shift_a_q[0];
            b         = shift_b_q[0];
            bit_first = (cnt_q == '0);
            bit_last  = last_w;
            carry_clr = last_w | abort_w;
            in_ready  = last_w & ~abort_w;
            if (abort_w) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (last_w) begin
               if (in_valid) begin
                  cnt_d     = '0;
                  shift_a_d = in_a;
                  shift_b_d = in_b;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d     = cnt_q + 1'b1;
               shift_a_d = shift_a_q >> 1;
               shift_b_d = shift_b_q >> 1;
            end
         end
      endcase

      // Reset masks the outputs in the same cycle so the adder carry clears.
      if (rst) begin
         in_ready  = 1'b1;
         bit_valid = 1'b0;
         a         = 1'b0;
         b         = 1'b0;
         bit_first = 1'b0;
         bit_last  = 1'b0;
         carry_clr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_a_q <= '0;
         shift_b_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
      end
   end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Self-checking bench for serial_operand_feeder driving a serial adder model.
// Abort scenario is built only when SERIAL_FEEDER_ABORT_EN is defined.
module tb_serial_operand_feeder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         a, b, bit_valid, bit_first, bit_last, carry_clr;
`ifdef SERIAL_FEEDER_ABORT_EN
   logic         abort = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Serial adder fed by the DUT; carry_clr acts as its reset.
   logic carry = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk)
      carry <= carry_clr ? 1'b0 : ((a & b) | (a & carry) | (b & carry));

   serial_operand_feeder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef SERIAL_FEEDER_ABORT_EN
      .abort     (abort),
`endif
      .a         (a),
      .b         (b),
      .bit_valid (bit_valid),
      .bit_first (bit_first),
      .bit_last  (bit_last),
      .carry_clr (carry_clr)
   );

   // Presents one word, then records what the serial side shows for W cycles.
   task automatic run_word(input logic [W-1:0] A, input logic [W-1:0] B,
                           output logic [W-1:0] s, output logic [W-1:0] aw,
                           output logic [W-1:0] bw, output int nv,
                           output int fpos, output int lpos);
      in_valid = 1'b1;
      in_a = A;
      in_b = B;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      s = '0; aw = '0; bw = '0;
      nv = 0; fpos = -1; lpos = -1;
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         if (bit_valid) nv++;
         if (bit_first && fpos < 0) fpos = k;
         if (bit_last && lpos < 0) lpos = k;
         aw[k] = a;
         bw[k] = b;
         s[k]  = a ^ b ^ carry;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         in_a = W'($urandom);
         in_b = W'($urandom);
         @(negedge clk);
         checks++;
         if ({in_ready, bit_valid, carry_clr, a, b, bit_first, bit_last}
             !== 7'b1010000) begin
            errors++;
            $display("FAIL reset_outputs: got %b exp 1010000",
                     {in_ready, bit_valid, carry_clr, a, b, bit_first, bit_last});
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0 || carry_clr !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_accept: bit_valid=%b carry_clr=%b exp 0 1",
                  bit_valid, carry_clr);
      end
   endtask

   task automatic test_idle();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         in_a = W'($urandom);
         in_b = W'($urandom);
         @(negedge clk);
         checks++;
         if ({in_ready, carry_clr, bit_valid, a, b} !== 5'b11000) begin
            errors++;
            $display("FAIL idle_hold: got %b exp 11000",
                     {in_ready, carry_clr, bit_valid, a, b});
         end
      end
   endtask

   task automatic test_pattern();
      logic [W-1:0] ea, eb, s, ex;
      ea = 8'b0011_0101;
      eb = 8'b0000_1111;
      s  = '0;
      ex = 8'h44;
      in_valid = 1'b1;
      in_a = 8'h35;
      in_b = 8'h0F;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      for (int c = 1; c <= W; c++) begin
         @(negedge clk);
         s[c-1] = a ^ b ^ carry;
         checks++;
         if (a !== ea[c-1] || b !== eb[c-1] || bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL pattern_bits c%0d: a=%b b=%b v=%b exp %b %b 1",
                     c, a, b, bit_valid, ea[c-1], eb[c-1]);
         end
         checks++;
         if (bit_first !== (c == 1) || bit_last !== (c == W) ||
             carry_clr !== (c == W) || in_ready !== (c == W)) begin
            errors++;
            $display("FAIL pattern_flags c%0d: f=%b l=%b cc=%b rdy=%b",
                     c, bit_first, bit_last, carry_clr, in_ready);
         end
      end
      checks++;
      if (s !== ex) begin
         errors++;
         $display("FAIL pattern_sum: got %h exp %h", s, ex);
      end
   endtask

   task automatic test_adder();
      logic [W-1:0] s, aw, bw;
      int nv, fp, lp;
      run_word(8'hFF, 8'h01, s, aw, bw, nv, fp, lp);
      checks++;
      if (s !== 8'h00) begin
         errors++;
         $display("FAIL adder_ff01: got %h exp 00", s);
      end
      @(negedge clk);
      run_word(8'h35, 8'h0F, s, aw, bw, nv, fp, lp);
      checks++;
      if (s !== 8'h44) begin
         errors++;
         $display("FAIL adder_after_carry: got %h exp 44", s);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] s;
      s = '0;
      in_valid = 1'b1;
      in_a = 8'hFF;
      in_b = 8'hFF;
      @(posedge clk);
      #1;
      in_a = 8'h01;
      in_b = 8'h02;
      for (int c = 1; c <= 2 * W; c++) begin
         @(negedge clk);
         s[c-1] = a ^ b ^ carry;
         checks++;
         if (bit_valid !== 1'b1 || in_ready !== (c == W || c == 2 * W)) begin
            errors++;
            $display("FAIL b2b_cycle c%0d: v=%b rdy=%b", c, bit_valid, in_ready);
         end
         if (c == W) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
         end
      end
      checks++;
      if (s[7:0] !== 8'hFE || s[15:8] !== 8'h03) begin
         errors++;
         $display("FAIL b2b_sums: got %h %h exp fe 03", s[7:0], s[15:8]);
      end
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_after: bit_valid=%b exp 0", bit_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s, aw, bw;
      int nv, fp, lp;
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0 || carry_clr !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_during: v=%b cc=%b exp 0 1", bit_valid, carry_clr);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0 || carry_clr !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_after: v=%b cc=%b rdy=%b exp 0 1 1",
                  bit_valid, carry_clr, in_ready);
      end
      run_word(8'h10, 8'h20, s, aw, bw, nv, fp, lp);
      checks++;
      if (s !== 8'h30 || nv != W) begin
         errors++;
         $display("FAIL rst_mid_next_sum: got %h nv=%0d exp 30 %0d", s, nv, W);
      end
   endtask

`ifdef SERIAL_FEEDER_ABORT_EN
   task automatic test_abort();
      logic [W-1:0] s, aw, bw;
      int nv, fp, lp;
      @(negedge clk);
      in_valid = 1'b1;
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(negedge clk);
      checks++;
      if (carry_clr !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_cycle: cc=%b rdy=%b exp 1 0", carry_clr, in_ready);
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: v=%b exp 0", bit_valid);
      end
      run_word(8'h07, 8'h01, s, aw, bw, nv, fp, lp);
      checks++;
      if (s !== 8'h08) begin
         errors++;
         $display("FAIL abort_next_sum: got %h exp 08", s);
      end
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] A, B, ex, s, aw, bw;
      int nv, fp, lp, gap;
      @(negedge clk);
      for (int i = 0; i < 24; i++) begin
         A = W'($urandom);
         B = W'($urandom);
         ex = A + B;
         run_word(A, B, s, aw, bw, nv, fp, lp);
         checks++;
         if (s !== ex || aw !== A || bw !== B) begin
            errors++;
            $display("FAIL rand_word %0d: s=%h a=%h b=%h exp %h %h %h",
                     i, s, aw, bw, ex, A, B);
         end
         checks++;
         if (nv != W || fp != 0 || lp != W - 1) begin
            errors++;
            $display("FAIL rand_framing %0d: nv=%0d first=%0d last=%0d exp %0d 0 %0d",
                     i, nv, fp, lp, W, W - 1);
         end
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_pattern();
      @(negedge clk);
      test_adder();
      @(negedge clk);
      test_back_to_back();
      test_reset_mid();
`ifdef SERIAL_FEEDER_ABORT_EN
      test_abort();
`endif
      test_random();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
